// File: rtl/proc_timers_pkg.sv
// proc_timers_pkg: shared constants for the process timer bank.
// Control op bit positions, read register codes, write-word field positions.
package proc_timers_pkg;

    // ctrl op bit indices (data_in[7:0])
    localparam int CTRL_TCLR  = 0;  // clear all ticker counters
    localparam int CTRL_PER   = 1;  // load ticker period
    localparam int CTRL_BIND  = 2;  // bind timer to ticker
    localparam int CTRL_CLR   = 3;  // clear ready/overrun
    localparam int CTRL_EN    = 4;  // enable timer
    localparam int CTRL_DIS   = 5;  // disable timer
    localparam int CTRL_FORCE = 6;  // force ready
    localparam int CTRL_BANK  = 7;  // select read bank

    // read register select codes
    localparam logic [1:0] RD_READY = 2'd0;
    localparam logic [1:0] RD_OVR   = 2'd1;
    localparam logic [1:0] RD_EN    = 2'd2;
    localparam logic [1:0] RD_CAP   = 2'd3;

    // write word field positions
    localparam int CTRL_LSB  = 0;
    localparam int WHICH_LSB = 8;
    localparam int DATA_LSB  = 16;

    // bind data bits
    localparam int BIND_ONESHOT = 15;
    localparam int BIND_IRQEN   = 14;

    localparam int TSEL_W = 4;
    localparam int BANK_W = 3;

endpackage

// File: rtl/proc_timer_cell.sv
// proc_timer_cell: one process timer (ticker select, mode, enable, ready,
// sticky overrun). irqen storage exists only with PROC_TIMERS_IRQ_EN.
module proc_timer_cell
    import proc_timers_pkg::*;
#(
    parameter int NUM_TICKERS = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_TICKERS-1:0]       expire,
    input  logic                         sel,
    input  logic [CTRL_FORCE:CTRL_BIND]  ops,
    input  logic [TSEL_W-1:0]            bind_tsel,
    input  logic                         bind_oneshot,
`ifdef PROC_TIMERS_IRQ_EN
    input  logic                         bind_irqen,
    output logic                         irq_req,
`endif
    output logic                         en,
    output logic                         ready,
    output logic                         overrun
);

    logic [TSEL_W-1:0]      tsel;
    logic                   oneshot;
    logic [2**TSEL_W-1:0]   exp_pad;
    logic                   hit;
    logic                   en_wr;

    // expiry of the bound ticker, and enable state as it stands after a write
    always_comb begin
        exp_pad                  = '0;
        exp_pad[NUM_TICKERS-1:0] = expire;
        hit   = en & exp_pad[tsel];
        en_wr = (en | ops[CTRL_BIND] | ops[CTRL_EN]) & ~ops[CTRL_DIS];
    end

`ifdef PROC_TIMERS_IRQ_EN
    logic irqen;

    // interrupt enable latched on bind
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            irqen <= 1'b0;
        else if (sel && ops[CTRL_BIND])
            irqen <= bind_irqen;
    end

    assign irq_req = ready & irqen;
`endif

    // bus write takes priority over a coincident expiry, which is dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tsel    <= '0;
            oneshot <= 1'b0;
            en      <= 1'b0;
            ready   <= 1'b0;
            overrun <= 1'b0;
        end else if (sel) begin
            if (ops[CTRL_BIND]) begin
                tsel    <= bind_tsel & TSEL_W'(NUM_TICKERS - 1);
                oneshot <= bind_oneshot;
            end
            en <= en_wr;
            if (ops[CTRL_BIND] || ops[CTRL_CLR]) begin
                ready   <= 1'b0;
                overrun <= 1'b0;
            end
            if (ops[CTRL_FORCE] && en_wr)
                ready <= 1'b1;
        end else if (hit) begin
            ready <= 1'b1;
            if (ready)
                overrun <= 1'b1;
            if (oneshot)
                en <= 1'b0;
        end
    end

endmodule

// File: rtl/proc_timers_gen.sv
// proc_timers_gen: bank of NUM_TIMERS periodic/one-shot process timers fed
// by NUM_TICKERS shared tick dividers; zero-wait-state IO bus slave.
// Optional masked level interrupt enabled by defining PROC_TIMERS_IRQ_EN.
module proc_timers_gen
    import proc_timers_pkg::*;
#(
    parameter int NUM_TIMERS  = 32,
    parameter int NUM_TICKERS = 8,
    parameter int PERIOD_W    = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stb,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic        tick,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        ack,
    output logic        irq
);

    logic                   wr;
    logic [7:0]             ctrl;
    logic [7:0]             which;
    logic [15:0]            wdata;
    logic                   tkr_ok;
    logic [BANK_W-1:0]      bank;

    assign wr     = stb & we;
    assign ctrl   = data_in[CTRL_LSB +: 8];
    assign which  = data_in[WHICH_LSB +: 8];
    assign wdata  = data_in[DATA_LSB +: 16];
    assign tkr_ok = 32'(which) < NUM_TICKERS;
    assign ack    = stb;

    // ---------------- tickers ----------------
    logic [NUM_TICKERS-1:0][PERIOD_W-1:0] period;
    logic [NUM_TICKERS-1:0][PERIOD_W-1:0] cnt;
    logic [NUM_TICKERS-1:0]               tclr;
    logic [NUM_TICKERS-1:0]               per_wr;
    logic [NUM_TICKERS-1:0]               expire;

    for (genvar i = 0; i < NUM_TICKERS; i++) begin : g_tkr
        assign per_wr[i] = wr & tkr_ok & ctrl[CTRL_PER] & (which == 8'(i));
        assign tclr[i]   = (wr & tkr_ok & ctrl[CTRL_TCLR]) | per_wr[i];
        // a counter clear on the same edge suppresses the expiry
        assign expire[i] = tick & ~tclr[i] & (period[i] != '0)
                         & (cnt[i] == period[i] - PERIOD_W'(1));

        // period load and tick counting; wraps to 0 on expiry
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                period[i] <= '0;
                cnt[i]    <= '0;
            end else begin
                if (per_wr[i])
                    period[i] <= wdata[PERIOD_W-1:0];
                if (tclr[i] || expire[i])
                    cnt[i] <= '0;
                else if (tick && period[i] != '0)
                    cnt[i] <= cnt[i] + PERIOD_W'(1);
            end
        end
    end

    // ---------------- timers ----------------
    logic [NUM_TIMERS-1:0] en_v, rdy_v, ovr_v, tmr_sel;
`ifdef PROC_TIMERS_IRQ_EN
    logic [NUM_TIMERS-1:0] irq_v;
`endif

    for (genvar i = 0; i < NUM_TIMERS; i++) begin : g_tmr
        assign tmr_sel[i] = wr & (which == 8'(i)) & (|ctrl[CTRL_FORCE:CTRL_BIND]);

        proc_timer_cell #(
            .NUM_TICKERS (NUM_TICKERS)
        ) u_cell (
            .clk          (clk),
            .rst_n        (rst_n),
            .expire       (expire),
            .sel          (tmr_sel[i]),
            .ops          (ctrl[CTRL_FORCE:CTRL_BIND]),
            .bind_tsel    (wdata[TSEL_W-1:0]),
            .bind_oneshot (wdata[BIND_ONESHOT]),
`ifdef PROC_TIMERS_IRQ_EN
            .bind_irqen   (wdata[BIND_IRQEN]),
            .irq_req      (irq_v[i]),
`endif
            .en           (en_v[i]),
            .ready        (rdy_v[i]),
            .overrun      (ovr_v[i])
        );
    end

    // read bank select
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bank <= '0;
        else if (wr && ctrl[CTRL_BANK])
            bank <= wdata[BANK_W-1:0];
    end

`ifdef PROC_TIMERS_IRQ_EN
    // level interrupt: any ready timer with its interrupt enabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            irq <= 1'b0;
        else
            irq <= |irq_v;
    end
`else
    assign irq = 1'b0;
`endif

    // ---------------- read-back ----------------
    logic [255:0] rdy_pad, ovr_pad, en_pad;
    logic [7:0]   base;

    // zero-extend status vectors to the full 8-bank space and select window
    always_comb begin
        rdy_pad = '0;
        ovr_pad = '0;
        en_pad  = '0;
        rdy_pad[NUM_TIMERS-1:0] = rdy_v;
        ovr_pad[NUM_TIMERS-1:0] = ovr_v;
        en_pad[NUM_TIMERS-1:0]  = en_v;
        base     = {bank, 5'd0};
        data_out = '0;
        if (rst_n && stb && !we) begin
            case (addr)
                RD_READY: data_out = rdy_pad[base +: 32];
                RD_OVR:   data_out = ovr_pad[base +: 32];
                RD_EN:    data_out = en_pad[base +: 32];
                RD_CAP:   data_out = {8'd0, 8'(NUM_TICKERS), 8'(NUM_TIMERS), 5'd0, bank};
                default:  data_out = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_proc_timers_gen.sv
// tb_proc_timers_gen: directed test of proc_timers_gen (64 timers, 8 tickers)
// against a behavioural model checked every cycle, plus literal expectations.
module tb_proc_timers_gen;

    localparam int NT = 64;
    localparam int NK = 8;
`ifdef PROC_TIMERS_IRQ_EN
    localparam logic IRQ_EXP = 1'b1;
`else
    localparam logic IRQ_EXP = 1'b0;
`endif

    logic        clk = 0, rst_n, stb = 0, we = 0, tick = 0;
    logic [1:0]  addr = 0;
    logic [31:0] data_in = 0, data_out;
    logic        ack, irq;

    int vectors = 0, miscompares = 0;

    proc_timers_gen #(.NUM_TIMERS(NT), .NUM_TICKERS(NK), .PERIOD_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .stb(stb), .we(we), .addr(addr), .tick(tick),
        .data_in(data_in), .data_out(data_out), .ack(ack), .irq(irq)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int m_per[NK], m_since[NK];
    int m_tsel[NT];
    bit m_os[NT], m_ie[NT], m_en[NT], m_rdy[NT], m_ovr[NT];
    int m_bank;
    bit m_irq;

    task automatic m_reset();
        for (int t = 0; t < NK; t++) begin m_per[t] = 0; m_since[t] = 0; end
        for (int i = 0; i < NT; i++) begin
            m_tsel[i] = 0; m_os[i] = 0; m_ie[i] = 0;
            m_en[i] = 0; m_rdy[i] = 0; m_ovr[i] = 0;
        end
        m_bank = 0; m_irq = 0;
    endtask

    task automatic m_step();
        bit       w_on = stb && we;
        bit [7:0] c    = data_in[7:0];
        int       w    = int'(data_in[15:8]);
        bit [15:0] d   = data_in[31:16];
        bit       fired[NK];
        bit       any_irq = 0;
        for (int i = 0; i < NT; i++) if (m_rdy[i] && m_ie[i]) any_irq = 1;
        // tickers: count ticks since last expiry, expire when it reaches period
        for (int t = 0; t < NK; t++) begin
            fired[t] = 0;
            if (w_on && w < NK && c[1] && w == t) m_per[t] = int'(d);
            if (w_on && w < NK && (c[0] || (c[1] && w == t))) m_since[t] = 0;
            else if (tick && m_per[t] != 0) begin
                m_since[t]++;
                if (m_since[t] == m_per[t]) begin fired[t] = 1; m_since[t] = 0; end
            end
        end
        // timers: ops applied in bit order, later ones override earlier ones
        for (int i = 0; i < NT; i++) begin
            if (w_on && w == i && (c & 8'h7C) != 0) begin
                if (c[2]) begin
                    m_tsel[i] = int'(d[3:0]) % NK; m_os[i] = d[15];
`ifdef PROC_TIMERS_IRQ_EN
                    m_ie[i] = d[14];
`endif
                    m_en[i] = 1; m_rdy[i] = 0; m_ovr[i] = 0;
                end
                if (c[3]) begin m_rdy[i] = 0; m_ovr[i] = 0; end
                if (c[4]) m_en[i] = 1;
                if (c[5]) m_en[i] = 0;
                if (c[6] && m_en[i]) m_rdy[i] = 1;
            end else if (m_en[i] && fired[m_tsel[i]]) begin
                if (m_rdy[i]) m_ovr[i] = 1;
                m_rdy[i] = 1;
                if (m_os[i]) m_en[i] = 0;
            end
        end
        if (w_on && c[7]) m_bank = int'(d) % 8;
        m_irq = any_irq;
    endtask

    function automatic logic [31:0] m_out();
        logic [31:0] r = '0;
        if (!rst_n || !stb || we) return '0;
        if (addr == 2'd3) return {8'd0, 8'(NK), 8'(NT), 5'd0, 3'(m_bank)};
        for (int k = 0; k < 32; k++) begin
            int idx = 32 * m_bank + k;
            if (idx < NT)
                r[k] = (addr == 2'd0) ? m_rdy[idx] : (addr == 2'd1) ? m_ovr[idx] : m_en[idx];
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_reset();
        else        m_step();
    end

    // every-cycle comparison against the model
    always @(negedge clk) begin
        vectors++;
        if (ack !== stb || data_out !== m_out() || irq !== m_irq) begin
            miscompares++;
            if (miscompares <= 20)
                $display("FAIL cycle_cmp t=%0t data_out=%h want %h ack=%b want %b irq=%b want %b",
                         $time, data_out, m_out(), ack, stb, irq, m_irq);
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic wr(input logic [7:0] c, input logic [7:0] w, input logic [15:0] d,
                      input logic tk = 1'b0);
        stb = 1; we = 1; data_in = {d, w, c}; tick = tk;
        @(posedge clk); #1;
        stb = 0; we = 0; data_in = 0; tick = 0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string nm);
        stb = 1; we = 0; addr = a;
        #1 chk(nm, data_out, exp);
        @(posedge clk); #1;
        stb = 0;
    endtask

    task automatic do_tick(input int n);
        repeat (n) begin
            tick = 1; @(posedge clk); #1;
            tick = 0; @(posedge clk); #1;
        end
    endtask

    initial begin
        rst_n = 1;
        #1 rst_n = 0;
        stb = 1; addr = 2'd3;
        #1 chk("reset_dout", data_out, 32'h0);
        chk("reset_irq", irq, 32'h0);
        stb = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        rd(2'd3, 32'h0008_4000, "cap_bank0");
        rd(2'd0, 32'h0, "reset_ready");

        // periodic: ticker 2 period 5, timer 7
        wr(8'h02, 8'd2, 16'd5);
        wr(8'h04, 8'd7, 16'd2);
        do_tick(4);  rd(2'd0, 32'h0,  "per_t4");
        do_tick(1);  rd(2'd0, 32'h80, "per_t5");
        wr(8'h08, 8'd7, 16'd0); rd(2'd0, 32'h0, "per_clr");
        do_tick(4);  rd(2'd0, 32'h0,  "per_t9");
        do_tick(1);  rd(2'd0, 32'h80, "per_t10");
        do_tick(2);  rd(2'd1, 32'h0,  "per_no_ovr");
        wr(8'h28, 8'd7, 16'd0); rd(2'd2, 32'h0, "per_dis");

        // one-shot: ticker 1 period 3, timer 3
        wr(8'h02, 8'd1, 16'd3);
        wr(8'h04, 8'd3, 16'h8001);
        do_tick(2);  rd(2'd0, 32'h0, "os_t2");
        do_tick(1);  rd(2'd0, 32'h8, "os_t3");
        rd(2'd2, 32'h0, "os_en_off");
        do_tick(6);  rd(2'd0, 32'h8, "os_t9");
        rd(2'd1, 32'h0, "os_no_ovr");

        // overrun: ticker 0 period 2, timer 0
        wr(8'h02, 8'd0, 16'd2);
        wr(8'h04, 8'd0, 16'd0);
        do_tick(4);  rd(2'd1, 32'h1, "ovr_set");
        rd(2'd0, 32'h9, "ovr_ready");
        wr(8'h08, 8'd0, 16'd0);
        rd(2'd0, 32'h8, "ovr_clr_rdy");
        rd(2'd1, 32'h0, "ovr_clr_ovr");
        wr(8'h28, 8'd3, 16'd0); rd(2'd0, 32'h0, "os_cleared");

        // collision: clear to timer 5 on the edge of its ticker expiry
        wr(8'h04, 8'd5, 16'd0);
        do_tick(1);
        wr(8'h08, 8'd5, 16'd0, 1'b1);
        rd(2'd0, 32'h1, "coll_ready");
        rd(2'd1, 32'h0, "coll_ovr");
        do_tick(2);
        rd(2'd0, 32'h21, "coll_next_rdy");
        rd(2'd1, 32'h1,  "coll_next_ovr");
        wr(8'h28, 8'd0, 16'd0);
        wr(8'h28, 8'd5, 16'd0);
        rd(2'd0, 32'h0, "coll_cleared");

        // banking and write filtering
        wr(8'h44, 8'd40, 16'd7);     // bind to idle ticker 7 and force ready
        wr(8'h40, 8'd41, 16'd0);     // force on disabled timer: no effect
        wr(8'h30, 8'd42, 16'd0);     // disable dominates enable
        wr(8'h02, 8'd8,  16'd1);     // ticker out of range: ignored
        wr(8'h04, 8'd64, 16'd0);     // timer out of range: ignored
        wr(8'h80, 8'd0,  16'd1);
        rd(2'd0, 32'h100, "bank1_ready");
        rd(2'd2, 32'h100, "bank1_en");
        rd(2'd3, 32'h0008_4001, "cap_bank1");
        wr(8'h80, 8'd0, 16'd2);
        rd(2'd0, 32'h0, "bank2_ready");
        rd(2'd3, 32'h0008_4002, "cap_bank2");
        wr(8'h80, 8'd0, 16'd0);
        rd(2'd0, 32'h0, "bank0_ready");

        // interrupt timing and async reset
        wr(8'h01, 8'd0, 16'd0);
        wr(8'h04, 8'd1, 16'h4000);
        do_tick(1);
        tick = 1; @(posedge clk); #1; tick = 0;
        chk("irq_pre", irq, 32'h0);
        rd(2'd0, 32'h2, "irq_ready");
        chk("irq_rise", irq, 32'(IRQ_EXP));
        wr(8'h08, 8'd1, 16'd0);
        chk("irq_hold", irq, 32'(IRQ_EXP));
        @(posedge clk); #1;
        chk("irq_fall", irq, 32'h0);
        do_tick(3);
        chk("irq_again", irq, 32'(IRQ_EXP));
        stb = 1; we = 0; addr = 2'd3;
        rst_n = 0;
        #1 chk("arst_dout", data_out, 32'h0);
        chk("arst_irq", irq, 32'h0);
        @(posedge clk); #1;
        rst_n = 1; stb = 0;
        rd(2'd0, 32'h0, "arst_ready");
        rd(2'd2, 32'h0, "arst_en");
        rd(2'd3, 32'h0008_4000, "arst_cap");
        wr(8'h04, 8'd0, 16'd0);       // ticker 0 period reset to 0: idle
        do_tick(3);
        rd(2'd0, 32'h0, "idle_ticker");

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
